z80_port_latch_ctrl: RTL and testbench

- Bus-side controller that sits directly upstream of the octal tri-state register (kr1533ir23) in the CPLD.
- Watches the asynchronous Z80 I/O bus and decodes a configurable port.
- Captures the written byte, then drives the register's D, C (rising-edge clock) and OEn inputs with clean, glitch-free timing.
- Supports an optional write-lock bit, as used by the memory-paging port.

---
 rtl/z80_port_latch_ctrl.sv | 130 +++++++++++++
 tb/tb_z80_port_latch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_port_latch_ctrl.sv
// Z80 I/O port decoder driving a kr1533ir23 octal register: captures the written
// byte, then issues one clean rising edge on latch_c per decoded write bus cycle.
//
// state    | meaning
// IDLE     | waiting for a decoded write
// SETUP    | latch_d stable, latch_c low for SETUP_CYCLES clocks
// STROBE   | latch_c high for two clocks
// WAIT_END | waiting for the bus cycle to end
module z80_port_latch_ctrl #(
  parameter logic [15:0] PORT_MASK    = 16'h8002,
  parameter logic [15:0] PORT_MATCH   = 16'h0000,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter bit          LOCK_EN      = 1'b1,
  parameter int unsigned LOCK_BIT     = 5,
  parameter bit          OE_MODE      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [7:0]  d_in,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic        m1_n,
  output logic [7:0]  latch_d,
  output logic        latch_c,
  output logic        latch_oen,
  output logic        locked,
  output logic        busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETUP    = 2'd1;
  localparam logic [1:0] STROBE   = 2'd2;
  localparam logic [1:0] WAIT_END = 2'd3;

  logic [1:0] iorq_sy, wr_sy, rd_sy, m1_sy;
  logic       s_iorq, s_wr, s_rd, s_m1;
  logic [1:0] sync_vld;
  logic       armed;
  logic       hit, wr_det, rd_det;
  logic [1:0] state;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sy  <= 2'b11;
      wr_sy    <= 2'b11;
      rd_sy    <= 2'b11;
      m1_sy    <= 2'b11;
      sync_vld <= 2'b00;
    end else begin
      iorq_sy  <= {iorq_sy[0], iorq_n};
      wr_sy    <= {wr_sy[0], wr_n};
      rd_sy    <= {rd_sy[0], rd_n};
      m1_sy    <= {m1_sy[0], m1_n};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign s_iorq = iorq_sy[1];
  assign s_wr   = wr_sy[1];
  assign s_rd   = rd_sy[1];
  assign s_m1   = m1_sy[1];

  // A write cycle still in progress across a reset must not strobe again:
  // writes are accepted only after the bus has been seen idle post-reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else if (sync_vld[1] && (s_iorq || s_wr)) armed <= 1'b1;
  end

  assign hit    = ((a & PORT_MASK) == PORT_MATCH);
  assign wr_det = !s_iorq && !s_wr && s_rd && s_m1 && hit;
  assign rd_det = !s_iorq && !s_rd && s_wr && s_m1 && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      latch_d <= 8'h00;
      latch_c <= 1'b0;
      locked  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_det && armed) begin
            if (!locked) begin
              latch_d <= d_in;
              cnt     <= 4'(SETUP_CYCLES - 1);
              state   <= SETUP;
            end else begin
              state <= WAIT_END;
            end
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            state   <= STROBE;
            latch_c <= 1'b1;
            cnt     <= 4'd1;
            if (LOCK_EN && latch_d[LOCK_BIT]) locked <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            latch_c <= 1'b0;
            state   <= WAIT_END;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WAIT_END: begin
          if (s_iorq || s_wr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) latch_oen <= 1'b1;
    else        latch_oen <= OE_MODE ? !rd_det : 1'b0;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_z80_port_latch_ctrl.sv
// Bench for z80_port_latch_ctrl: one instance with permanent output enable,
// one with read-gated output enable, both on the same bus.
module tb_z80_port_latch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        iorq_n, wr_n, rd_n, m1_n;
  logic [7:0]  latch_d0, latch_d1;
  logic        c0, c1, oen0, oen1, locked0, locked1, busy0, busy1;

  z80_port_latch_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .d_in(d_in), .iorq_n(iorq_n), .wr_n(wr_n),
    .rd_n(rd_n), .m1_n(m1_n), .latch_d(latch_d0), .latch_c(c0), .latch_oen(oen0),
    .locked(locked0), .busy(busy0)
  );

  z80_port_latch_ctrl #(.OE_MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .d_in(d_in), .iorq_n(iorq_n), .wr_n(wr_n),
    .rd_n(rd_n), .m1_n(m1_n), .latch_d(latch_d1), .latch_c(c1), .latch_oen(oen1),
    .locked(locked1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int hi_cyc = 0;

  always @(posedge c0) pulses++;
  always @(negedge clk) if (c0 === 1'b1) hi_cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        m1;
    int          exp_pulses;
    logic [7:0]  exp_d;
    logic        exp_lock;
  } vec_t;

  typedef struct {
    int         pulses;
    logic [7:0] d;
    logic       lock;
  } exp_t;

  exp_t sb[$];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input logic m1);
    @(negedge clk);
    a = addr; d_in = data; m1_n = m1; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (8) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    int p0, h0;
    exp_t e;

    vecs[0] = '{1'b1, 16'h7FFD, 8'h55, 1'b1, 1, 8'h55, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFD, 8'hAA, 1'b1, 1, 8'hAA, 1'b1};
    vecs[2] = '{1'b0, 16'h7FFF, 8'h33, 1'b1, 0, 8'hAA, 1'b1};
    vecs[3] = '{1'b1, 16'h7FFD, 8'h20, 1'b1, 1, 8'h20, 1'b1};
    vecs[4] = '{1'b0, 16'h7FFD, 8'h07, 1'b1, 0, 8'h20, 1'b1};
    vecs[5] = '{1'b1, 16'h0000, 8'h11, 1'b1, 1, 8'h11, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 8'h44, 1'b1, 0, 8'h11, 1'b0};
    vecs[7] = '{1'b0, 16'h7FFD, 8'h99, 1'b0, 0, 8'h11, 1'b0};
    vecs[8] = '{1'b0, 16'h7FFD, 8'h1F, 1'b1, 1, 8'h1F, 1'b0};

    rst_n = 1'b0; a = 16'h0000; d_in = 8'h00;
    iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
    #12;
    chk("rst_latch_d", latch_d0, 8'h00);
    chk("rst_latch_c", c0, 1'b0);
    chk("rst_oen", oen0, 1'b1);
    chk("rst_locked", locked0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("oen0_after_edge1", oen0, 1'b0);
    chk("oen1_after_edge1", oen1, 1'b1);
    repeat (4) @(negedge clk);

    // write latency, edges counted from the bus going low
    @(negedge clk);
    a = 16'h7FFD; d_in = 8'h55; iorq_n = 1'b0; wr_n = 1'b0;
    for (int ed = 1; ed <= 8; ed++) begin
      @(negedge clk);
      chk($sformatf("lat_c_edge%0d", ed), c0, (ed == 4 || ed == 5) ? 1'b1 : 1'b0);
      chk($sformatf("lat_busy_edge%0d", ed), busy0, (ed >= 3) ? 1'b1 : 1'b0);
      if (ed >= 3) chk($sformatf("lat_d_edge%0d", ed), latch_d0, 8'h55);
      else         chk($sformatf("lat_d_edge%0d", ed), latch_d0, 8'h00);
    end
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("wait_end_busy_edge10", busy0, 1'b1);
    @(negedge clk);
    chk("idle_busy_edge11", busy0, 1'b0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      p0 = pulses; h0 = hi_cyc;
      sb.push_back('{vecs[i].exp_pulses, vecs[i].exp_d, vecs[i].exp_lock});
      bus_write(vecs[i].addr, vecs[i].data, vecs[i].m1);
      e = sb.pop_front();
      chk($sformatf("v%0d_pulses", i), pulses - p0, e.pulses);
      chk($sformatf("v%0d_high_cycles", i), hi_cyc - h0, 2 * e.pulses);
      chk($sformatf("v%0d_latch_d", i), latch_d0, e.d);
      chk($sformatf("v%0d_locked", i), locked0, e.lock);
      chk($sformatf("v%0d_busy", i), busy0, 1'b0);
      chk($sformatf("v%0d_oen0", i), oen0, 1'b0);
      chk($sformatf("v%0d_oen1", i), oen1, 1'b1);
    end
    do_reset();
    chk("lock_cleared", locked0, 1'b0);
    chk("latch_d_cleared", latch_d0, 8'h00);

    // reset while latch_c is high, bus cycle still active afterwards
    @(negedge clk);
    a = 16'h7FFD; d_in = 8'h0F; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("strobe_before_reset", c0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_c", c0, 1'b0);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_latch_d", latch_d0, 8'h00);
    p0 = pulses;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_pulse_same_cycle", pulses - p0, 0);
    chk("no_busy_same_cycle", busy0, 1'b0);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulses;
    bus_write(16'h7FFD, 8'h0F, 1'b1);
    chk("fresh_write_pulse", pulses - p0, 1);
    chk("fresh_write_d", latch_d0, 8'h0F);

    // read-gated output enable
    @(negedge clk);
    a = 16'h7FFD; iorq_n = 1'b0; rd_n = 1'b0;
    for (int ed = 1; ed <= 6; ed++) begin
      @(negedge clk);
      chk($sformatf("rd_oen1_edge%0d", ed), oen1, (ed >= 3) ? 1'b0 : 1'b1);
    end
    iorq_n = 1'b1; rd_n = 1'b1;
    for (int ed = 7; ed <= 9; ed++) begin
      @(negedge clk);
      chk($sformatf("rd_oen1_edge%0d", ed), oen1, (ed <= 8) ? 1'b0 : 1'b1);
    end
    chk("rd_oen0_fixed", oen0, 1'b0);
    repeat (2) @(negedge clk);

    a = 16'h00FE; iorq_n = 1'b0; rd_n = 1'b0;
    for (int ed = 1; ed <= 6; ed++) begin
      @(negedge clk);
      chk($sformatf("rd_miss_oen1_edge%0d", ed), oen1, 1'b1);
    end
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);

    // interrupt acknowledge on the decoded address
    p0 = pulses;
    a = 16'h7FFD; iorq_n = 1'b0; m1_n = 1'b0;
    for (int ed = 1; ed <= 6; ed++) begin
      @(negedge clk);
      chk($sformatf("iack_oen1_edge%0d", ed), oen1, 1'b1);
      chk($sformatf("iack_busy_edge%0d", ed), busy0, 1'b0);
    end
    iorq_n = 1'b1; m1_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("iack_no_pulse", pulses - p0, 0);
    chk("iack_latch_d", latch_d0, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
